// File: rtl/rv_fetch_pkg.sv
// Shared fetch types and constants for the RISC-V front end.
package rv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// The head is read straight out of the storage registers, so there is no path from pop to the outputs.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  fetch_entry_t  i_wdata,
    output fetch_entry_t  o_head,
    output logic          o_valid,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // Storage keeps stale data; only the pointers and count are cleared.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, addresses instruction memory and queues
// returned words for decode. A redirect flushes the queue and restarts fetch.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset_n,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic [31:0]  r_pc;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic [31:0]  w_redirect_target;
    fetch_entry_t w_wentry;
    fetch_entry_t w_head;

    assign w_redirect_target = redirect_pc & ~32'h0000_0003;

    // Redirect takes priority: no push, and the head is not consumed.
    assign w_pop  = out_valid & out_ready & ~redirect_valid;
    assign w_push = ~redirect_valid & (~w_full | w_pop);

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign imem_addr = {2'b00, r_pc[31:2]};
    assign w_wentry  = '{pc: r_pc, instr: imem_instr};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (SYS_clk),
        .i_rst_n (SYS_reset_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wentry),
        .o_head  (w_head),
        .o_valid (out_valid),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front end of the RISC-V core: owns the program counter, drives the word address into the instruction memory, and captures the returned instruction with its PC into a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. Decode stalls are absorbed without losing fetched words. A redirect from execute (branch/jump) flushes the FIFO and restarts fetch at the new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- DEPTH, 2, FIFO entries (power of two, ≥ 2)

Ports:
- SYS_clk  in  1  single clock, all state on rising edge
- SYS_reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  word index into instruction memory = {2'b00, pc[31:2]}
- imem_instr  in  32  instruction memory read data, combinational from imem_addr
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced 0)
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  byte PC of head instruction
- out_instr  out  32  head instruction word
- fifo_count  out  $clog2(DEPTH)+1  occupied entries (debug/verification)

## Operation
- State: pc (32 b, byte address), FIFO of {pc, instr} entries, count.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count < DEPTH | pop).
- On push: entry {pc, imem_instr} written at tail; pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- No push: pc holds; imem_addr stays stable.
- Redirect (priority over push and pop): FIFO emptied (count <= 0, pointers reset); pc <= {redirect_pc[31:2], 2'b00}. Head is not considered consumed even if out_ready was high.
- Full with simultaneous pop: push allowed, count unchanged.
- Empty: out_valid = 0; out_pc and out_instr hold stale entry contents, which decode must ignore.
- FIFO read/write pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert on the next SYS_clk edge): pc = RESET_PC, count = 0, out_valid = 0, out_pc = 0, out_instr = 0, fifo_count = 0, imem_addr = RESET_PC >> 2. FIFO storage is cleared to 0.
- Reset asserted mid-operation: all in-flight entries are discarded immediately, without waiting for a clock edge.
- Fetch-to-decode latency: address driven in cycle N, instruction visible on out_* in cycle N+1.
- Throughput: one instruction per cycle while decode is ready.
- Redirect in cycle N: out_valid = 0 in cycle N+1, target instruction presented in cycle N+2. The redirect penalty is 1 bubble beyond the redirect cycle.
- Back-to-back redirects: the last one wins. Each redirect flushes.
- out_* are driven from registers only. No combinational path from out_ready to out_valid/out_pc/out_instr. Combinational path exists from out_ready/redirect_valid to imem_addr hold decision only via pc update (registered), so none within the cycle.

## Structure
- Shared package rv_fetch_pkg: RESET_PC default, NOP constant 32'h0000_0013, fetch entry typedef {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: parameterised DEPTH synchronous FIFO with flush, push/pop, count, registered head. Instantiated once.
- Top: pc register, push/pop/redirect control, imem_addr formation.

## Test plan
- Reset then out_ready = 1, memory word k = k: out_pc sequence 0,4,8,… with out_instr 0,1,2,… starting cycle 1 after reset release, one per cycle.
- out_ready = 0 for 5 cycles: fifo_count reaches 2 and stays; imem_addr frozen at 2. Release yields out_pc 0,4,8 with no skips or duplicates.
- redirect_valid with redirect_pc = 32'h0000_0103 while full and out_ready = 1: next cycle out_valid = 0 and fifo_count = 0; following cycle out_pc = 32'h100, out_instr = word 64.
- pc = 32'hFFFF_FFFC, ready high: entries at FFFF_FFFC then 0000_0000, with imem_addr 3FFF_FFFF then 0.
- SYS_reset_n pulsed low mid-stream with FIFO at 1 entry: out_valid drops in the same cycle without a clock edge; after release, fetch restarts at RESET_PC.
- Redirect in two consecutive cycles (targets 0x40, 0x80): only 0x80 stream appears; no 0x40 instruction ever reaches out_valid.
